// File: rtl/scatter_threshold.sv
// scatter_threshold: magnitude-threshold outlier scatter with element/column/block-latched masks and a registered valid/ready output
module scatter_threshold #(
  parameter int IN_WIDTH = 16,
  parameter int IN_SIZE = 4,
  parameter int IN_PARALLELISM = 1,
  parameter int IN_DEPTH = 1,
  parameter int MODE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic [IN_WIDTH-2:0] threshold,
  input  logic [IN_WIDTH*IN_SIZE*IN_PARALLELISM-1:0] data_in,
  input  logic data_in_valid,
  output logic data_in_ready,
  output logic [IN_WIDTH*IN_SIZE*IN_PARALLELISM-1:0] data_out_large,
  output logic [IN_WIDTH*IN_SIZE*IN_PARALLELISM-1:0] data_out_small,
  output logic [IN_SIZE*IN_PARALLELISM-1:0] data_out_mask,
  output logic [$clog2(IN_SIZE+1)-1:0] outlier_count,
  output logic data_out_last,
  output logic data_out_valid,
  input  logic data_out_ready
);
  localparam int N = IN_SIZE * IN_PARALLELISM;
  localparam int DW = IN_WIDTH * N;
  localparam int CW = $clog2(IN_SIZE + 1);
  localparam int BW = IN_DEPTH > 1 ? $clog2(IN_DEPTH) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(IN_DEPTH - 1);
  logic [DW-1:0] large_q, large_d, small_q, small_d;
  logic [N-1:0] mask_q, mask_d, hot;
  logic [CW-1:0] count_q, count_d;
  logic last_q, last_d, valid_q, valid_d, accept;
  logic [BW-1:0] beat_q, beat_d;
  logic [IN_SIZE-1:0] col_q, col_d, col_hot, col_sel;
  assign data_in_ready = !valid_q || data_out_ready;
  assign accept = data_in_valid && data_in_ready;
  assign data_out_large = large_q;
  assign data_out_small = small_q;
  assign data_out_mask = mask_q;
  assign outlier_count = count_q;
  assign data_out_last = last_q;
  assign data_out_valid = valid_q;
  always_comb begin
    hot = '0;
    col_hot = '0;
    for (int i = 0; i < N; i++) hot[i] = data_in[i*IN_WIDTH +: IN_WIDTH-1] > threshold;
    for (int i = 0; i < N; i++) col_hot[i % IN_SIZE] = col_hot[i % IN_SIZE] | hot[i];
    col_sel = (MODE == 2 && beat_q != '0) ? col_q : col_hot;
    large_d = large_q;
    small_d = small_q;
    mask_d = mask_q;
    count_d = count_q;
    last_d = last_q;
    beat_d = beat_q;
    col_d = col_q;
    valid_d = accept || (valid_q && !data_out_ready);
    if (accept) begin
      beat_d = beat_q == LAST_BEAT ? '0 : beat_q + 1'b1;
      col_d = col_sel;
      last_d = beat_q == LAST_BEAT;
      count_d = '0;
      for (int c = 0; c < IN_SIZE; c++) count_d = count_d + CW'(col_sel[c]);
      for (int i = 0; i < N; i++) begin
        mask_d[i] = MODE == 0 ? hot[i] : col_sel[i % IN_SIZE];
        large_d[i*IN_WIDTH +: IN_WIDTH] = mask_d[i] ? data_in[i*IN_WIDTH +: IN_WIDTH] : '0;
        small_d[i*IN_WIDTH +: IN_WIDTH] = mask_d[i] ? '0 : data_in[i*IN_WIDTH +: IN_WIDTH];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      large_q <= '0;
      small_q <= '0;
      mask_q <= '0;
      count_q <= '0;
      last_q <= 1'b0;
      valid_q <= 1'b0;
      beat_q <= '0;
      col_q <= '0;
    end else begin
      large_q <= large_d;
      small_q <= small_d;
      mask_q <= mask_d;
      count_q <= count_d;
      last_q <= last_d;
      valid_q <= valid_d;
      beat_q <= beat_d;
      col_q <= col_d;
    end
  end
endmodule

// File: tb/tb_scatter_threshold.sv
// tb_scatter_threshold: three-mode bench comparing scatter_threshold against a per-beat reference model
module tb_scatter_threshold;
  localparam int MODES [3] = '{0, 1, 2};
  localparam int DEPTH [3] = '{1, 1, 3};
  typedef struct packed {
    logic [127:0] l;
    logic [127:0] s;
    logic [7:0] m;
    logic [2:0] c;
  } res_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [14:0] thr = 15'h4800;
  logic [127:0] din = '0;
  logic vin = 1'b0;
  logic rdy = 1'b1;
  logic [127:0] lg [3];
  logic [127:0] sm [3];
  logic [7:0] mk [3];
  logic [2:0] ct [3];
  logic lst [3];
  logic ov [3];
  logic ir [3];
  res_t er [3];
  logic ev [3];
  logic elast [3];
  int beat [3];
  logic [3:0] lat [3];
  int errors = 0;
  int checks = 0;
  logic [127:0] snap;
  always #5 clk = ~clk;
  scatter_threshold #(.IN_WIDTH(16), .IN_SIZE(4), .IN_PARALLELISM(2), .IN_DEPTH(1), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .threshold(thr), .data_in(din), .data_in_valid(vin), .data_in_ready(ir[0]),
    .data_out_large(lg[0]), .data_out_small(sm[0]), .data_out_mask(mk[0]), .outlier_count(ct[0]),
    .data_out_last(lst[0]), .data_out_valid(ov[0]), .data_out_ready(rdy));
  scatter_threshold #(.IN_WIDTH(16), .IN_SIZE(4), .IN_PARALLELISM(2), .IN_DEPTH(1), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .threshold(thr), .data_in(din), .data_in_valid(vin), .data_in_ready(ir[1]),
    .data_out_large(lg[1]), .data_out_small(sm[1]), .data_out_mask(mk[1]), .outlier_count(ct[1]),
    .data_out_last(lst[1]), .data_out_valid(ov[1]), .data_out_ready(rdy));
  scatter_threshold #(.IN_WIDTH(16), .IN_SIZE(4), .IN_PARALLELISM(2), .IN_DEPTH(3), .MODE(2)) u2 (
    .clk(clk), .rst(rst), .threshold(thr), .data_in(din), .data_in_valid(vin), .data_in_ready(ir[2]),
    .data_out_large(lg[2]), .data_out_small(sm[2]), .data_out_mask(mk[2]), .outlier_count(ct[2]),
    .data_out_last(lst[2]), .data_out_valid(ov[2]), .data_out_ready(rdy));
  function automatic logic [7:0] hot_of(logic [127:0] d, logic [14:0] t);
    logic [7:0] h;
    h = '0;
    for (int i = 0; i < 8; i++) h[i] = (int'(d[i*16 +: 16]) & 32'h7fff) > int'(t);
    return h;
  endfunction
  function automatic logic [3:0] colsel(int mode, logic [127:0] d, logic [14:0] t, bit first, logic [3:0] latch);
    logic [7:0] h;
    logic [3:0] ch;
    h = hot_of(d, t);
    ch = '0;
    for (int i = 0; i < 8; i++) if (h[i]) ch[i % 4] = 1'b1;
    return (mode == 2 && !first) ? latch : ch;
  endfunction
  function automatic res_t model(int mode, logic [127:0] d, logic [14:0] t, bit first, logic [3:0] latch);
    res_t r;
    logic [7:0] h;
    logic [3:0] cs;
    int n;
    r = '0;
    n = 0;
    h = hot_of(d, t);
    cs = colsel(mode, d, t, first, latch);
    for (int i = 0; i < 8; i++) begin
      r.m[i] = mode == 0 ? h[i] : cs[i % 4];
      if (r.m[i]) r.l[i*16 +: 16] = d[i*16 +: 16];
      else r.s[i*16 +: 16] = d[i*16 +: 16];
    end
    for (int c = 0; c < 4; c++) n += int'(cs[c]);
    r.c = 3'(n);
    return r;
  endfunction
  function automatic logic [127:0] el(logic [127:0] d, int r, int c, logic [15:0] v);
    logic [127:0] x;
    x = d;
    x[(r*4 + c)*16 +: 16] = v;
    return x;
  endfunction
  function automatic logic [15:0] rel(logic [14:0] t);
    case ($urandom_range(0, 6))
      0: return {1'($urandom_range(0, 1)), t};
      1: return {1'b1, t + 15'd1};
      2: return 16'h8000;
      3: return 16'hFE00;
      default: return 16'($urandom);
    endcase
  endfunction
  function automatic logic [127:0] rbeat(logic [14:0] t);
    logic [127:0] d;
    for (int i = 0; i < 8; i++) d[i*16 +: 16] = rel(t);
    return d;
  endfunction
  task automatic chk(string nm, logic [127:0] a, logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, a, e, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(logic [127:0] d);
    din = d;
    vin = 1'b1;
    step();
    vin = 1'b0;
  endtask
  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        er[k] <= '0;
        ev[k] <= 1'b0;
        elast[k] <= 1'b0;
        beat[k] <= 0;
        lat[k] <= '0;
      end else if (vin && (!ev[k] || rdy)) begin
        er[k] <= model(MODES[k], din, thr, beat[k] == 0, lat[k]);
        lat[k] <= colsel(MODES[k], din, thr, beat[k] == 0, lat[k]);
        ev[k] <= 1'b1;
        elast[k] <= beat[k] == DEPTH[k] - 1;
        beat[k] <= beat[k] == DEPTH[k] - 1 ? 0 : beat[k] + 1;
      end else if (rdy) begin
        ev[k] <= 1'b0;
      end
    end
  end
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d large", k), lg[k], er[k].l);
      chk($sformatf("u%0d small", k), sm[k], er[k].s);
      chk($sformatf("u%0d mask", k), 128'(mk[k]), 128'(er[k].m));
      chk($sformatf("u%0d count", k), 128'(ct[k]), 128'(er[k].c));
      chk($sformatf("u%0d last", k), 128'(lst[k]), 128'(elast[k]));
      chk($sformatf("u%0d valid", k), 128'(ov[k]), 128'(ev[k]));
      chk($sformatf("u%0d in_ready", k), 128'(ir[k]), 128'(!ev[k] || rdy));
    end
  end
  initial begin
    logic [127:0] d, b1;
    repeat (2) step();
    chk("reset large", lg[2], 128'h0);
    chk("reset valid", 128'(ov[2]), 128'h0);
    rst = 1'b0;
    d = el(el(el(el('0, 0, 0, 16'h3C00), 0, 1, 16'hC900), 0, 2, 16'h4800), 0, 3, 16'h0000);
    for (int c = 0; c < 4; c++) d = el(d, 1, c, 16'h3C00);
    send(d);
    chk("m0 mask", 128'(mk[0]), 128'h02);
    chk("m0 large", lg[0], 128'hC900_0000);
    chk("m0 small", sm[0], d & ~128'hFFFF_0000);
    chk("m0 count", 128'(ct[0]), 128'd1);
    chk("m0 last", 128'(lst[0]), 128'd1);
    pulse_rst();
    d = '0;
    for (int i = 0; i < 8; i++) d = el(d, i / 4, i % 4, 16'h3C00);
    d = el(el(d, 0, 1, 16'hC900), 1, 3, 16'h7C00);
    send(d);
    chk("m1 mask", 128'(mk[1]), 128'hAA);
    chk("m1 count", 128'(ct[1]), 128'd2);
    chk("m1 large r0c3", 128'(lg[1][48 +: 16]), 128'h3C00);
    chk("m1 elem mask", 128'(mk[0]), 128'h82);
    pulse_rst();
    d = el('0, 0, 2, 16'h5000);
    send(d);
    chk("m2 b0 mask", 128'(mk[2]), 128'h44);
    chk("m2 b0 large", lg[2], d);
    chk("m2 b0 last", 128'(lst[2]), 128'd0);
    chk("m2 b0 count", 128'(ct[2]), 128'd1);
    b1 = el('0, 0, 0, 16'h5000);
    thr = 15'h7FFF;
    send(b1);
    thr = 15'h4800;
    chk("m2 b1 mask", 128'(mk[2]), 128'h44);
    chk("m2 b1 small", sm[2], b1);
    chk("m2 b1 last", 128'(lst[2]), 128'd0);
    chk("m2 b1 count", 128'(ct[2]), 128'd1);
    send(b1);
    chk("m2 b2 large", lg[2], 128'h0);
    chk("m2 b2 last", 128'(lst[2]), 128'd1);
    send(el('0, 1, 1, 16'h6000));
    chk("m2 b3 mask", 128'(mk[2]), 128'h22);
    chk("m2 b3 last", 128'(lst[2]), 128'd0);
    pulse_rst();
    send(el('0, 0, 3, 16'h5000));
    send(b1);
    pulse_rst();
    chk("rst mid large", lg[2], 128'h0);
    chk("rst mid mask", 128'(mk[2]), 128'h0);
    chk("rst mid valid", 128'(ov[2]), 128'h0);
    send(el('0, 1, 0, 16'h5000));
    chk("rst x mask", 128'(mk[2]), 128'h11);
    chk("rst x last", 128'(lst[2]), 128'd0);
    send('0);
    chk("rst y mask", 128'(mk[2]), 128'h11);
    chk("rst y last", 128'(lst[2]), 128'd0);
    send('0);
    chk("rst z mask", 128'(mk[2]), 128'h11);
    chk("rst z last", 128'(lst[2]), 128'd1);
    snap = lg[2];
    rdy = 1'b0;
    vin = 1'b1;
    din = rbeat(thr);
    for (int j = 0; j < 3; j++) begin
      step();
      chk("bp valid", 128'(ov[0]), 128'd1);
      chk("bp in_ready", 128'(ir[0]), 128'd0);
      chk("bp hold", lg[2], snap);
    end
    rdy = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step();
      din = rbeat(thr);
    end
    vin = 1'b0;
    for (int j = 0; j < 400; j++) begin
      rst = $urandom_range(0, 63) == 0;
      vin = $urandom_range(0, 3) != 0;
      rdy = $urandom_range(0, 9) < 7;
      if ($urandom_range(0, 7) == 0) thr = $urandom_range(0, 1) ? 15'($urandom) : 15'h4800;
      din = rbeat(thr);
      step();
    end
    rst = 1'b0;
    vin = 1'b0;
    rdy = 1'b1;
    pulse_rst();
    for (int j = 0; j < 16; j++) begin
      din = rbeat(thr);
      vin = 1'b1;
      step();
      chk("stream valid", 128'(ov[0]), 128'd1);
      for (int k = 0; k < 3; k++) chk($sformatf("stream u%0d union", k), lg[k] | sm[k], din);
    end
    vin = 1'b0;
    step();
    chk("stream drain", 128'(ov[0]), 128'd0);
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
